pipe: RTL and testbench

PIPE -- requirements
Module: pipe

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_reg.sv | 16 +
 rtl/pipe.sv | 39 +++
 tb/tb_pipe.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared width constant and stage helper for the pipe datapath
package pipe_pkg;
  localparam int unsigned N_DEF = 10;
  // stage-1 combinational term: wrapped sum, wrapped difference and a copy of d
  function automatic logic [3*N_DEF-1:0] stage1_word(
    input logic [N_DEF-1:0] a,
    input logic [N_DEF-1:0] b,
    input logic [N_DEF-1:0] c,
    input logic [N_DEF-1:0] d
  );
    logic [N_DEF-1:0] s;
    logic [N_DEF-1:0] m;
    s = a + b;
    m = c - d;
    return {s, m, d};
  endfunction
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: width-parameterized D register with asynchronous active-low clear
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  // capture d on each rising edge, clear immediately on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/pipe.sv
// pipe: three-stage pipeline computing Y = ((A + B) + (C - D)) * D modulo 2^N
module pipe
  import pipe_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  output logic [N-1:0] Y
);
  logic [N-1:0]   sum1_d, diff1_d;
  logic [3*N-1:0] st1_d, st1_q;
  logic [N-1:0]   sum2_d;
  logic [2*N-1:0] st2_d, st2_q;
  logic [N-1:0]   y_d, y_q;
  // stage 1: wrapped sum of A and B, wrapped difference C - D, and D carried along
  always_comb begin
    sum1_d  = A + B;
    diff1_d = C - D;
    st1_d   = {sum1_d, diff1_d, D};
  end
  pipe_reg #(.W(3*N)) u_st1 (.clk(clk), .rst_n(rst_n), .d_i(st1_d), .q_o(st1_q));
  // stage 2: combine the stage-1 sum and difference, keep this set's own D
  always_comb begin
    sum2_d = st1_q[3*N-1:2*N] + st1_q[2*N-1:N];
    st2_d  = {sum2_d, st1_q[N-1:0]};
  end
  pipe_reg #(.W(2*N)) u_st2 (.clk(clk), .rst_n(rst_n), .d_i(st2_d), .q_o(st2_q));
  // stage 3: product truncated to N bits by the N-bit assignment context
  always_comb begin
    y_d = st2_q[2*N-1:N] * st2_q[N-1:0];
  end
  pipe_reg #(.W(N)) u_st3 (.clk(clk), .rst_n(rst_n), .d_i(y_d), .q_o(y_q));
  assign Y = y_q;
endmodule

// File: tb/tb_pipe.sv
// tb_pipe: directed self-checking bench for the pipe datapath
module tb_pipe;
  logic       clk;
  logic       rst_n;
  logic [9:0] A, B, C, D;
  logic [9:0] Y;
  int vec;
  int err;

  pipe dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .Y(Y));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    A = a; B = b; C = c; D = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)),
            10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)));
      #1;
      vec++;
      if (Y !== 10'd0) begin
        err++;
        $display("FAIL reset[%0d]: Y=%0d expected 0", i, Y);
      end
    end
  endtask

  task automatic test_latency();
    logic [9:0] exp;
    @(negedge clk);
    rst_n = 1'b1;
    drive(10'd5, 10'd10, 10'd15, 10'd20);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      drive(10'd0, 10'd0, 10'd0, 10'd0);
      exp = (e == 2) ? 10'd200 : 10'd0;
      vec++;
      if (Y !== exp) begin
        err++;
        $display("FAIL latency[edge k+%0d]: Y=%0d expected %0d", e, Y, exp);
      end
    end
  endtask

  task automatic test_stream();
    logic [9:0] sa[6], sb[6], sc[6], sd[6], ex[6];
    sa = '{10'd4, 10'd3, 10'd6, 10'd8, 10'd10, 10'd9};
    sb = '{10'd8, 10'd6, 10'd12, 10'd16, 10'd20, 10'd18};
    sc = '{10'd12, 10'd9, 10'd18, 10'd24, 10'd30, 10'd27};
    sd = '{10'd16, 10'd12, 10'd24, 10'd32, 10'd40, 10'd36};
    ex = '{10'd128, 10'd72, 10'd288, 10'd512, 10'd800, 10'd648};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        vec++;
        if (Y !== ex[i-3]) begin
          err++;
          $display("FAIL stream[%0d]: Y=%0d expected %0d", i - 3, Y, ex[i-3]);
        end
      end
      if (i < 6) drive(sa[i], sb[i], sc[i], sd[i]);
      else       drive(10'd0, 10'd0, 10'd0, 10'd0);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive(10'd1023, 10'd1, 10'd0, 10'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (Y !== 10'd1023) begin
      err++;
      $display("FAIL wrap: Y=%0d expected 1023", Y);
    end
  endtask

  task automatic test_trunc();
    logic [9:0] ta[3], tb[3], tc[3], td[3], ex[3];
    ta = '{10'd0, 10'd100, 10'd64};
    tb = '{10'd0, 10'd0, 10'd0};
    tc = '{10'd40, 10'd0, 10'd32};
    td = '{10'd0, 10'd0, 10'd16};
    ex = '{10'd0, 10'd0, 10'd256};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(10'd1, 10'd2, 10'd3, 10'd5);
      @(negedge clk);
      drive(ta[i], tb[i], tc[i], td[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      vec++;
      if (Y !== ex[i]) begin
        err++;
        $display("FAIL trunc[%0d]: Y=%0d expected %0d", i, Y, ex[i]);
      end
    end
  endtask

  task automatic test_midflight();
    logic [9:0] exp;
    @(negedge clk);
    drive(10'd4, 10'd8, 10'd12, 10'd16);
    @(negedge clk);
    drive(10'd3, 10'd6, 10'd9, 10'd12);
    @(negedge clk);
    drive(10'd6, 10'd12, 10'd18, 10'd24);
    @(negedge clk);
    vec++;
    if (Y !== 10'd128) begin
      err++;
      $display("FAIL midflight_pre: Y=%0d expected 128", Y);
    end
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (Y !== 10'd0) begin
      err++;
      $display("FAIL midflight_async: Y=%0d expected 0", Y);
    end
    #1 rst_n = 1'b1;
    drive(10'd5, 10'd10, 10'd15, 10'd20);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      drive(10'd0, 10'd0, 10'd0, 10'd0);
      exp = (e == 2) ? 10'd200 : 10'd0;
      vec++;
      if (Y !== exp) begin
        err++;
        $display("FAIL midflight_refill[%0d]: Y=%0d expected %0d", e, Y, exp);
      end
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    rst_n = 1'b0;
    drive(10'd0, 10'd0, 10'd0, 10'd0);
    test_reset();
    test_latency();
    test_stream();
    test_wrap();
    test_trunc();
    test_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
